// File: rtl/security_test_pkg.sv
// security_test_pkg
//   Shared types and constants for the security_test_unit intrusion-alarm
//   controller: FSM state encoding, default parameter values and counter
//   widths.
package security_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CHECK = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam int unsigned PIN_WINDOW_DEF = 8;
    localparam int unsigned MAX_FAIL_DEF   = 3;

    localparam int unsigned WIN_W  = 8;
    localparam int unsigned FAIL_W = 4;

endpackage

// File: rtl/security_test_window_timer.sv
// security_test_window_timer
//   Loadable down-counter that times the PIN entry window.
//   Ports:
//     clk        in  system clock, rising edge
//     rst_n      in  asynchronous active-low reset (count -> 0)
//     load_i     in  load load_val_i (has priority over dec_i)
//     dec_i      in  decrement by one; ignored when already zero
//     load_val_i in  value to load
//     zero_o     out count is zero
module security_test_window_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/security_test_unit.sv
// security_test_unit
//   Intrusion-alarm controller for a door/lock subsystem. Arms on a rising
//   edge of LOCK, opens a PIN window when a key card is presented, counts
//   expired windows and latches a registered alarm on tamper or too many
//   failures. KC&PIN together disarm (and clear the alarm).
//   Ports:
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     KC     in  key card present (synchronised level)
//     PIN    in  correct PIN entered (synchronised level/strobe)
//     LOCK   in  lock engaged (level)
//     AL     out alarm, registered
//   Optional (macro SECURITY_TEST_STATUS_EN):
//     state_o    out current FSM state (IDLE=0 ARMED=1 CHECK=2 ALARM=3)
//     fail_cnt_o out current consecutive-failure count
module security_test_unit
    import security_test_pkg::*;
#(
    parameter int unsigned PIN_WINDOW = PIN_WINDOW_DEF,
    parameter int unsigned MAX_FAIL   = MAX_FAIL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              KC,
    input  logic              PIN,
    input  logic              LOCK,
    output logic              AL
`ifdef SECURITY_TEST_STATUS_EN
    ,
    output logic [1:0]        state_o,
    output logic [FAIL_W-1:0] fail_cnt_o
`endif
);

    localparam logic [WIN_W-1:0]  WIN_LOAD = WIN_W'(PIN_WINDOW - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

    state_t              state_q, state_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [FAIL_W-1:0]   fail_inc;
    logic                lock_q;
    logic                lock_rise;
    logic                al_q, al_d;
    logic                win_load, win_dec, win_zero;

    assign lock_rise = LOCK & ~lock_q;
    // Saturating increment so the count never wraps past MAX_FAIL.
    assign fail_inc  = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 1'b1;

    security_test_window_timer #(
        .W (WIN_W)
    ) u_win_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (win_load),
        .dec_i      (win_dec),
        .load_val_i (WIN_LOAD),
        .zero_o     (win_zero)
    );

    // State / counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fail_q  <= '0;
            lock_q  <= 1'b0;
            al_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            lock_q  <= LOCK;
            al_q    <= al_d;
        end
    end

    // Next-state: tamper beats credential beats timer in every state.
    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        win_load = 1'b0;
        win_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (lock_rise) begin
                    state_d = ARMED;
                    fail_d  = '0;
                end
            end
            ARMED: begin
                if (!LOCK) begin
                    state_d = ALARM;
                end else if (KC && PIN) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end else if (KC) begin
                    state_d  = CHECK;
                    win_load = 1'b1;
                end
            end
            CHECK: begin
                if (!LOCK) begin
                    state_d = ALARM;
                end else if (PIN) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end else if (win_zero) begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc >= FAIL_MAX) ? ALARM : ARMED;
                end else begin
                    win_dec = 1'b1;
                end
            end
            ALARM: begin
                if (KC && PIN) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            default: state_d = ALARM;
        endcase
    end

    // Output: alarm reflects the state being entered, registered once.
    always_comb begin
        al_d = (state_d == ALARM);
    end

    assign AL = al_q;

`ifdef SECURITY_TEST_STATUS_EN
    assign state_o    = state_q;
    assign fail_cnt_o = fail_q;
`endif

endmodule

// File: tb/tb_security_test_unit.sv
// tb_security_test_unit
//   Directed + short random bench for security_test_unit. Expected AL values
//   come from a behavioural reference model and travel through a scoreboard
//   queue from the stimulus step to the post-edge check.
module tb_security_test_unit;

    localparam int PW = 8;
    localparam int MF = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic KC, PIN, LOCK;
    logic AL;

    int errors = 0;
    int checks = 0;

    logic sb[$];

    // reference model state: 0 IDLE, 1 ARMED, 2 CHECK, 3 ALARM
    int m_state, m_fail, m_win;
    logic m_lock;

    security_test_unit #(
        .PIN_WINDOW (PW),
        .MAX_FAIL   (MF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .KC    (KC),
        .PIN   (PIN),
        .LOCK  (LOCK),
        .AL    (AL)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = 0;
        m_fail  = 0;
        m_win   = 0;
        m_lock  = 1'b0;
    endtask

    task automatic model_step(input logic kc, input logic pin, input logic lock);
        logic rise;
        int nf;
        rise = lock & ~m_lock;
        case (m_state)
            0: if (rise) begin m_state = 1; m_fail = 0; end
            1: begin
                if (!lock) m_state = 3;
                else if (kc && pin) begin m_state = 0; m_fail = 0; end
                else if (kc) begin m_state = 2; m_win = PW - 1; end
            end
            2: begin
                if (!lock) m_state = 3;
                else if (pin) begin m_state = 0; m_fail = 0; end
                else if (m_win == 0) begin
                    nf = (m_fail + 1 > MF) ? MF : m_fail + 1;
                    m_fail  = nf;
                    m_state = (nf >= MF) ? 3 : 1;
                end else m_win = m_win - 1;
            end
            default: if (kc && pin) begin m_state = 0; m_fail = 0; end
        endcase
        m_lock = lock;
    endtask

    task automatic check(input string tag, input logic exp);
        checks++;
        assert (AL === exp)
        else begin
            errors++;
            $error("FAIL %s: AL=%b expected %b", tag, AL, exp);
        end
    endtask

    // Drive one input vector, predict, clock once, then compare.
    task automatic step(input logic kc, input logic pin, input logic lock, input string tag);
        logic exp;
        KC   = kc;
        PIN  = pin;
        LOCK = lock;
        model_step(kc, pin, lock);
        sb.push_back(m_state == 3);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        check(tag, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        KC = 1'b0; PIN = 1'b0; LOCK = 1'b0;
        model_reset();
        #2;
        check("reset_al", 1'b0);
        #10;
        rst_n = 1'b1;

        // arm on LOCK rise
        step(0, 0, 0, "idle_lock_low");
        step(0, 0, 1, "arm_rise");
        step(0, 0, 1, "armed_hold");

        // KC&PIN disarm, holding LOCK does not re-arm; lock drop proves IDLE
        step(1, 1, 1, "disarm_kcpin");
        for (int i = 0; i < 3; i++) step(0, 0, 1, "idle_lock_held");
        step(0, 0, 0, "idle_probe_drop");
        step(0, 0, 1, "rearm");

        // PIN on window cycle 5
        step(1, 0, 1, "kc_open_window");
        for (int i = 0; i < 3; i++) step(0, 0, 1, "window_wait");
        step(0, 1, 1, "pin_cycle5");
        step(0, 0, 0, "pin_idle_probe");
        step(0, 0, 1, "rearm2");

        // three expired windows -> alarm
        for (int w = 0; w < MF; w++) begin
            step(1, 0, 1, "kc_no_pin");
            for (int i = 0; i < PW; i++) step(0, 0, 1, "window_expire");
        end
        check("alarm_after_third", 1'b1);
        step(0, 0, 0, "alarm_lock_low");
        step(0, 0, 1, "alarm_lock_high");
        step(1, 1, 1, "alarm_clear");
        check("alarm_cleared", 1'b0);

        // fail count cleared: one expiry must not alarm, then PIN on last window cycle
        step(0, 0, 0, "post_clear_low");
        step(0, 0, 1, "post_clear_arm");
        step(1, 0, 1, "kc_single_fail");
        for (int i = 0; i < PW; i++) step(0, 0, 1, "single_expire");
        step(1, 0, 1, "kc_last_cycle");
        for (int i = 0; i < PW - 1; i++) step(0, 0, 1, "last_wait");
        step(0, 1, 1, "pin_last_cycle");
        step(0, 0, 0, "last_idle_probe");

        // tamper from ARMED
        step(0, 0, 1, "tamper_arm");
        step(0, 0, 0, "tamper");
        check("tamper_alarm", 1'b1);

        // asynchronous reset mid-cycle while alarmed
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_al", 1'b0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(0, 0, 0, "post_reset_idle");
        step(0, 0, 1, "post_reset_arm");

        // short random run against the model
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
